serial_addsub_ctrl: RTL
=======================

# serial_addsub_ctrl

Bit-serial add/subtract sequencer built around a single `fas` full adder/subtractor cell. It accepts two N-bit operands and a mode on a `start` pulse, then steps them LSB-first through the one `fas` instance, one bit per clock, with the carry/borrow held in a flop. It returns an N-bit result, the carry/borrow out, and signed overflow, with a one-cycle `done` pulse. It is the sequencing layer that turns the combinational `fas` cell into a reusable arithmetic unit for the lab datapath.

## Interface
- `N`, default 8: operand/result width in bits; legal values 2..32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  operand A; captured on an accepted `start`.
- `b`  in  N  operand B; captured on an accepted `start`.
- `a_ns`  in  1  mode: 1 = A+B, 0 = A−B; captured on an accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `result`  out  N  sum/difference; valid from `done` until the next accepted `start`.
- `cout_o`  out  1  final carry (add) or borrow (subtract); same validity as `result`.
- `ovf`  out  1  signed two's-complement overflow; same validity as `result`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the bit counter reaches N−1.
  - DONE → IDLE unconditionally.
- Accepted `start` (IDLE only):
  - load shift registers `sa`←`a`, `sb`←`b`;
  - latch the mode;
  - clear the carry flop to 0 (no carry-in for add, no borrow-in for subtract);
  - set bit counter = 0.
- `start` in RUN or DONE is ignored; nothing is queued.
- `fas` hookup:
  - `a`=`sa[0]`, `b`=`sb[0]`, `cin`=carry flop, `a_ns`=latched mode.
  - Cell semantics: `s`=a⊕b⊕cin in both modes.
  - `cout`=maj(a,b,cin) when adding; `cout`=maj(¬a,b,cin) when subtracting, which is the borrow of a−b−bin.
- Each RUN cycle:
  - `sa`,`sb` shift right by one;
  - `result` shifts right with `s` entering the MSB;
  - carry flop ← `cout`;
  - counter increments.
- Final bit (counter = N−1):
  - `cout_o` ← `cout`;
  - `ovf` ← carry flop ⊕ `cout`, i.e. carry into the MSB XOR carry out of it. This is valid for both modes.
- `result`, `cout_o` and `ovf` hold their values through DONE and IDLE until the next accepted `start`, which clears them to 0.
- Reset values: `busy`=0, `done`=0, `result`=0, `cout_o`=0, `ovf`=0, state=IDLE, counter/shift registers/carry=0.
- Reset asserted mid-RUN aborts the operation with no `done` pulse; all outputs return to their reset values on that edge.
- Reset takes priority over `start` on the same edge.

## Timing
- `start` sampled high at edge k → RUN from edge k.
- Edges k+1 … k+N compute bits 0 … N−1; at edge k+N the state becomes DONE.
- `done`=1 for exactly the cycle between edges k+N and k+N+1; latency is N+1 cycles from the start edge.
- `busy`=1 from after edge k until edge k+N (N cycles).
- Earliest next accepted `start`: edge k+N+2, i.e. one IDLE cycle between operations.
- Minimum clock period is set by the `fas` gate delays. Worst path is XNOR→NAND→NAND on `cout` = 29 time units, plus flop setup. The bench runs `clk` at period ≥ 40.

## Structure
- Package `serial_addsub_pkg`:
  - state enum `ctrl_state_t` {IDLE, RUN, DONE};
  - constants `MODE_ADD`=1'b1 and `MODE_SUB`=1'b0.
- Counter width is $clog2(N), derived locally.
- Exactly one sub-module: a single `fas` instance, used unmodified. All sequencing, shift registers and flag logic live in `serial_addsub_ctrl`.

## Test plan
- N=8, add 0x3C+0x05 → `result`=0x41, `cout_o`=0, `ovf`=0; `done` exactly 9 cycles after the start edge; `busy` high for 8 cycles.
- Add 0xFF+0x01 → 0x00, `cout_o`=1, `ovf`=0. Add 0x7F+0x01 → 0x80, `cout_o`=0, `ovf`=1.
- Subtract 0x10−0x01 → 0x0F, `cout_o`=0. Subtract 0x00−0x01 → 0xFF, `cout_o`=1 (borrow), `ovf`=0. Subtract 0x80−0x01 → 0x7F, `ovf`=1.
- Change `a`/`b`/`a_ns` and pulse `start` while `busy` → ignored; result still matches the originally captured operands; exactly one `done`.
- Assert `rst` at bit 4 of a run → next cycle all outputs 0, state IDLE, no `done`; a fresh `start` then completes correctly.
- Back-to-back: hold `start` high continuously → operations accepted at edges k, k+N+2, …; `result` holds between `done` and the next accept.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/fas.sv
// Full adder/subtractor cell: sum is shared by both modes, carry-out becomes
// the borrow of a-b-bin when a_ns is low (operand a is inverted for the majority).
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic a_eff;

  // a passes through when adding and is inverted when subtracting
  always_comb begin
    a_eff = ~(a ^ a_ns);
    s     = a ^ b ^ cin;
    cout  = (a_eff & b) | (a_eff & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: steps two N-bit operands LSB-first
// through one fas cell, one bit per clock, with the carry/borrow in a flop.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold last operation
// RUN   | one operand bit per cycle through the fas cell
// DONE  | one-cycle completion pulse, result valid
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_ns,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout_o,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  ctrl_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sa, sb;
  logic          carry;
  logic          mode;
  logic          load;
  logic          last_bit;
  logic          s_bit, c_bit;

  fas u_fas (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .a_ns (mode),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign last_bit = (cnt == CW'(N - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; load marks an accepted start
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers, carry flop, bit counter and result/flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      mode   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_o <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      sa     <= a;
      sb     <= b;
      mode   <= a_ns;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_o <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      result <= {s_bit, result[N-1:1]};
      carry  <= c_bit;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        cout_o <= c_bit;
        // carry into the MSB versus carry out of it
        ovf    <= carry ^ c_bit;
      end
    end
  end

endmodule
